// File: rtl/rx_reset_seq_nch_if.sv
// ---------------------------------------------------------------------------
// rx_reset_seq_nch_if
//   Bundles the SERDES status pins and the per-channel PCS/SERDES reset
//   controls that pass between the RX reset sequencer and the SERDES/PCS.
//
//   Signals (NUM_CH bits unless noted):
//     rx_cdr_lol_ch_s     CDR loss of lock, async            SERDES -> seq
//     rx_los_low_ch_s     loss of signal, async              SERDES -> seq
//     tx_pll_lol_qd_s     quad TX PLL loss of lock (1 bit)   SERDES -> seq
//     power_down          channel power down                 system -> seq
//     fault_clr           FAULT clear pulse                  system -> seq
//     rx_pcs_rst_ch_c     RX PCS lane reset, active-high     seq -> PCS
//     rx_serdes_rst_ch_c  RX SERDES reset, active-high       seq -> SERDES
//     rx_ready            channel locked and running         seq -> system
//     rx_fault            retry budget exhausted             seq -> system
//
//   master: the sequencer side; slave: the SERDES/PCS/system side.
// ---------------------------------------------------------------------------
interface rx_reset_seq_nch_if #(
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] rx_cdr_lol_ch_s;
    logic [NUM_CH-1:0] rx_los_low_ch_s;
    logic              tx_pll_lol_qd_s;
    logic [NUM_CH-1:0] power_down;
    logic [NUM_CH-1:0] fault_clr;
    logic [NUM_CH-1:0] rx_pcs_rst_ch_c;
    logic [NUM_CH-1:0] rx_serdes_rst_ch_c;
    logic [NUM_CH-1:0] rx_ready;
    logic [NUM_CH-1:0] rx_fault;

    modport master (
        input  rx_cdr_lol_ch_s,
        input  rx_los_low_ch_s,
        input  tx_pll_lol_qd_s,
        input  power_down,
        input  fault_clr,
        output rx_pcs_rst_ch_c,
        output rx_serdes_rst_ch_c,
        output rx_ready,
        output rx_fault
    );

    modport slave (
        output rx_cdr_lol_ch_s,
        output rx_los_low_ch_s,
        output tx_pll_lol_qd_s,
        output power_down,
        output fault_clr,
        input  rx_pcs_rst_ch_c,
        input  rx_serdes_rst_ch_c,
        input  rx_ready,
        input  rx_fault
    );
endinterface

// File: rtl/rx_reset_seq_nch.sv
// ---------------------------------------------------------------------------
// rx_reset_seq_nch
//   N-channel SERDES RX reset sequencer. One independent reset FSM per RX
//   channel, gated by the shared quad TX PLL lock and the channel's own
//   CDR loss-of-lock / loss-of-signal. A channel that fails to hold lock
//   MAX_RETRY times in a row parks in FAULT until fault_clr.
//
//   Parameters:
//     NUM_CH     number of RX channels
//     T1_WIDTH   SERDES-reset pulse counter width (terminal bit T1_WIDTH-1)
//     T2_BIT     lock-stability timer terminal bit (19 silicon, 4 sim)
//     MAX_RETRY  failed lock attempts before FAULT; 0 disables FAULT
//
//   Ports:
//     refclkdiv2   clock, refclk/2
//     rst_n        synchronous active-low reset
//     sq_if        status inputs / reset control outputs (master modport)
//
//   State table (pcs_rst/serdes_rst):
//     state      | meaning
//     WAIT_PLL   | 1/0  wait for TX PLL lock, signal present, powered up
//     SERDES_RST | 1/1  start SERDES reset pulse, clear t1
//     WAIT_T1    | 1/1  hold SERDES reset until t1 terminal bit
//     CHECK      | 1/0  clear t2, (re)start lock-stability window
//     WAIT_T2    | 1/0  lock must stay stable for the whole t2 window
//     NORMAL     | 0/0  channel running, rx_ready
//     FAULT      | 1/0  retry budget spent, rx_fault, wait for fault_clr
// ---------------------------------------------------------------------------
module rx_reset_seq_nch #(
    parameter int NUM_CH    = 4,
    parameter int T1_WIDTH  = 2,
    parameter int T2_BIT    = 19,
    parameter int MAX_RETRY = 7
) (
    input  logic                 refclkdiv2,
    input  logic                 rst_n,
    rx_reset_seq_nch_if.master   sq_if
);

    // Keep the retry counter at least one bit wide so MAX_RETRY=0 still
    // elaborates; with MAX_RETRY=0 it saturates at 0 and FAULT is never hit.
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);
    localparam int T2_W  = T2_BIT + 1;
    localparam logic [RTY_W-1:0] RTY_MAX  = RTY_W'(MAX_RETRY);
    localparam bit               FAULT_EN = (MAX_RETRY != 0);

    typedef enum logic [2:0] {
        WAIT_PLL   = 3'd0,
        SERDES_RST = 3'd1,
        WAIT_T1    = 3'd2,
        CHECK      = 3'd3,
        WAIT_T2    = 3'd4,
        NORMAL     = 3'd5,
        FAULT      = 3'd6
    } state_t;

    // Shared quad PLL lock, one flop; resets to "unlocked".
    logic pll_s;

    always_ff @(posedge refclkdiv2) begin
        if (!rst_n) begin
            pll_s <= 1'b1;
        end else begin
            pll_s <= sq_if.tx_pll_lol_qd_s;
        end
    end

    logic [NUM_CH-1:0] pcs_rst_v;
    logic [NUM_CH-1:0] serdes_rst_v;
    logic [NUM_CH-1:0] ready_v;
    logic [NUM_CH-1:0] fault_v;

    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch

        // Input conditioning
        logic lol_los_del;
        logic lol_los_int;
        logic los_s;
        logic pd_s;
        logic lol_edge;

        always_ff @(posedge refclkdiv2) begin
            if (!rst_n) begin
                lol_los_del <= 1'b1;
                lol_los_int <= 1'b1;
                los_s       <= 1'b1;
                pd_s        <= 1'b0;
            end else begin
                lol_los_del <= sq_if.rx_cdr_lol_ch_s[gi] | sq_if.rx_los_low_ch_s[gi];
                lol_los_int <= lol_los_del;
                los_s       <= sq_if.rx_los_low_ch_s[gi];
                pd_s        <= sq_if.power_down[gi];
            end
        end

        // Any change of lock status seen by the second flop restarts the
        // stability window.
        assign lol_edge = (lol_los_int != lol_los_del);

        // FSM state and counters
        state_t               state_q, state_d;
        logic [T1_WIDTH-1:0]  t1_q, t1_d;
        logic [T2_W-1:0]      t2_q, t2_d;
        logic [RTY_W-1:0]     rty_q, rty_d;
        logic [RTY_W-1:0]     rty_inc;

        always_ff @(posedge refclkdiv2) begin
            if (!rst_n) begin
                state_q <= WAIT_PLL;
                t1_q    <= '0;
                t2_q    <= '0;
                rty_q   <= '0;
            end else begin
                state_q <= state_d;
                t1_q    <= t1_d;
                t2_q    <= t2_d;
                rty_q   <= rty_d;
            end
        end

        // Saturating increment: the retry count never wraps past MAX_RETRY.
        assign rty_inc = (rty_q == RTY_MAX) ? rty_q : rty_q + RTY_W'(1);

        // Next-state logic
        always_comb begin
            state_d = state_q;
            t1_d    = t1_q;
            t2_d    = t2_q;
            rty_d   = rty_q;
            if ((state_q != WAIT_PLL) && pd_s) begin
                state_d = WAIT_PLL;
                rty_d   = '0;
            end else if ((state_q != WAIT_PLL) && pll_s) begin
                state_d = WAIT_PLL;
            end else begin
                case (state_q)
                    WAIT_PLL: begin
                        if (!pll_s && !los_s && !pd_s) begin
                            state_d = SERDES_RST;
                        end
                    end
                    SERDES_RST: begin
                        t1_d    = '0;
                        state_d = WAIT_T1;
                    end
                    WAIT_T1: begin
                        if (t1_q[T1_WIDTH-1]) begin
                            state_d = CHECK;
                        end else begin
                            t1_d = t1_q + T1_WIDTH'(1);
                        end
                    end
                    CHECK: begin
                        t2_d    = '0;
                        state_d = WAIT_T2;
                    end
                    WAIT_T2: begin
                        if (lol_edge) begin
                            state_d = CHECK;
                        end else if (t2_q[T2_BIT]) begin
                            if (!lol_los_int) begin
                                state_d = NORMAL;
                                rty_d   = '0;
                            end else begin
                                rty_d = rty_inc;
                                if (FAULT_EN && (rty_inc == RTY_MAX)) begin
                                    state_d = FAULT;
                                end else begin
                                    state_d = WAIT_PLL;
                                end
                            end
                        end else begin
                            t2_d = t2_q + T2_W'(1);
                        end
                    end
                    NORMAL: begin
                        if (lol_los_int) begin
                            state_d = WAIT_PLL;
                        end
                    end
                    FAULT: begin
                        if (sq_if.fault_clr[gi]) begin
                            state_d = WAIT_PLL;
                            rty_d   = '0;
                        end
                    end
                    default: begin
                        state_d = WAIT_PLL;
                    end
                endcase
            end
        end

        // Output decode; the result is registered so outputs trail the
        // state by one cycle.
        logic pcs_rst_d, serdes_rst_d, ready_d, fault_d;
        logic pcs_rst_q, serdes_rst_q, ready_q, fault_q;

        always_comb begin
            pcs_rst_d    = (state_q != NORMAL);
            serdes_rst_d = (state_q == SERDES_RST) || (state_q == WAIT_T1);
            ready_d      = (state_q == NORMAL);
            fault_d      = (state_q == FAULT);
        end

        always_ff @(posedge refclkdiv2) begin
            if (!rst_n) begin
                pcs_rst_q    <= 1'b1;
                serdes_rst_q <= 1'b0;
                ready_q      <= 1'b0;
                fault_q      <= 1'b0;
            end else begin
                pcs_rst_q    <= pcs_rst_d;
                serdes_rst_q <= serdes_rst_d;
                ready_q      <= ready_d;
                fault_q      <= fault_d;
            end
        end

        assign pcs_rst_v[gi]    = pcs_rst_q;
        assign serdes_rst_v[gi] = serdes_rst_q;
        assign ready_v[gi]      = ready_q;
        assign fault_v[gi]      = fault_q;
    end

    assign sq_if.rx_pcs_rst_ch_c    = pcs_rst_v;
    assign sq_if.rx_serdes_rst_ch_c = serdes_rst_v;
    assign sq_if.rx_ready           = ready_v;
    assign sq_if.rx_fault           = fault_v;

endmodule

// File: tb/tb_rx_reset_seq_nch.sv
// ---------------------------------------------------------------------------
// tb_rx_reset_seq_nch
//   Bench for rx_reset_seq_nch with NUM_CH=2, T1_WIDTH=2, T2_BIT=4,
//   MAX_RETRY=3. Timing facts used for expectations (cycle k = sample
//   taken after the k-th rising edge following reset release):
//     - sync flops hold WAIT_PLL until edge 2, SERDES_RST state after edge 2
//     - serdes_rst output high cycles 3..6 (SERDES_RST 1 + WAIT_T1 3)
//     - CHECK 1 + WAIT_T2 17 cycles, so rx_ready rises at cycle 25
//     - one failed attempt is 23 cycles from SERDES_RST to SERDES_RST
// ---------------------------------------------------------------------------
module tb_rx_reset_seq_nch;

    localparam int NCH = 2;

    logic refclkdiv2 = 1'b0;
    logic rst_n      = 1'b0;

    always #5 refclkdiv2 = ~refclkdiv2;

    rx_reset_seq_nch_if #(.NUM_CH(NCH)) sq_if ();

    rx_reset_seq_nch #(
        .NUM_CH    (NCH),
        .T1_WIDTH  (2),
        .T2_BIT    (4),
        .MAX_RETRY (3)
    ) dut (
        .refclkdiv2 (refclkdiv2),
        .rst_n      (rst_n),
        .sq_if      (sq_if)
    );

    typedef struct {
        logic [1:0] lol;
        logic [1:0] los;
        logic [1:0] pd;
        logic       pll;
        int         cycles;
        logic [1:0] e_pcs;
        logic [1:0] e_ready;
        logic [1:0] e_fault;
    } vec_t;

    typedef struct {
        int         idx;
        logic [1:0] pcs;
        logic [1:0] serdes;
        logic [1:0] ready;
        logic [1:0] fault;
    } exp_t;

    vec_t vecs [8];
    exp_t sb [$];
    exp_t e;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int rises;
    int found;
    int c0;
    int s_on [2];
    int s_off [2];
    int r_on [2];
    int p_off [2];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(negedge refclkdiv2);
        cyc++;
    endtask

    task automatic drive(input logic [1:0] l, input logic [1:0] s, input logic [1:0] p,
                         input logic pl, input logic [1:0] f);
        sq_if.rx_cdr_lol_ch_s = l;
        sq_if.rx_los_low_ch_s = s;
        sq_if.power_down      = p;
        sq_if.tx_pll_lol_qd_s = pl;
        sq_if.fault_clr       = f;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        cyc   = 0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_pcs"},    32'(sq_if.rx_pcs_rst_ch_c),    32'd3);
        check({tag, "_serdes"}, 32'(sq_if.rx_serdes_rst_ch_c), 32'd0);
        check({tag, "_ready"},  32'(sq_if.rx_ready),           32'd0);
        check({tag, "_fault"},  32'(sq_if.rx_fault),           32'd0);
    endtask

    // Counts ch0 serdes_rst rising edges until rx_fault[0] is seen.
    task automatic run_until_fault(input int bound, output int n_rise, output int seen);
        logic prev;
        n_rise = 0;
        seen   = 0;
        prev   = sq_if.rx_serdes_rst_ch_c[0];
        for (int k = 0; k < bound; k++) begin
            step();
            if (sq_if.rx_serdes_rst_ch_c[0] && !prev) n_rise++;
            prev = sq_if.rx_serdes_rst_ch_c[0];
            if (sq_if.rx_fault[0]) begin
                seen = 1;
                break;
            end
        end
    endtask

    // Waits for the n-th ch0 serdes_rst rising edge.
    task automatic wait_rises(input int n, input int bound, output int seen);
        logic prev;
        int   cnt;
        cnt  = 0;
        seen = 0;
        prev = sq_if.rx_serdes_rst_ch_c[0];
        for (int k = 0; k < bound; k++) begin
            step();
            if (sq_if.rx_serdes_rst_ch_c[0] && !prev) cnt++;
            prev = sq_if.rx_serdes_rst_ch_c[0];
            if (cnt == n) begin
                seen = 1;
                break;
            end
        end
    endtask

    initial begin
        //            lol    los    pd     pll  cyc  pcs    ready  fault
        vecs[0] = '{2'b00, 2'b00, 2'b00, 1'b0, 60,  2'b00, 2'b11, 2'b00};
        vecs[1] = '{2'b00, 2'b10, 2'b00, 1'b0, 60,  2'b10, 2'b01, 2'b00};
        vecs[2] = '{2'b00, 2'b00, 2'b01, 1'b0, 60,  2'b01, 2'b10, 2'b00};
        vecs[3] = '{2'b00, 2'b00, 2'b00, 1'b1, 60,  2'b11, 2'b00, 2'b00};
        vecs[4] = '{2'b01, 2'b00, 2'b00, 1'b0, 120, 2'b01, 2'b10, 2'b01};
        vecs[5] = '{2'b11, 2'b00, 2'b00, 1'b0, 120, 2'b11, 2'b00, 2'b11};
        vecs[6] = '{2'b10, 2'b00, 2'b10, 1'b0, 120, 2'b10, 2'b01, 2'b00};
        vecs[7] = '{2'b00, 2'b11, 2'b00, 1'b0, 60,  2'b11, 2'b00, 2'b00};

        drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        rst_n = 1'b0;
        step();
        step();
        check_reset_vals("por");

        // Steady-state table
        for (int i = 0; i < 8; i++) begin
            drive(vecs[i].lol, vecs[i].los, vecs[i].pd, vecs[i].pll, 2'b00);
            do_reset();
            sb.push_back('{i, vecs[i].e_pcs, 2'b00, vecs[i].e_ready, vecs[i].e_fault});
            repeat (vecs[i].cycles) step();
            e = sb.pop_front();
            check($sformatf("vec%0d_pcs", e.idx),    32'(sq_if.rx_pcs_rst_ch_c),    32'(e.pcs));
            check($sformatf("vec%0d_serdes", e.idx), 32'(sq_if.rx_serdes_rst_ch_c), 32'(e.serdes));
            check($sformatf("vec%0d_ready", e.idx),  32'(sq_if.rx_ready),           32'(e.ready));
            check($sformatf("vec%0d_fault", e.idx),  32'(sq_if.rx_fault),           32'(e.fault));
        end

        // Clean lock on ch1, glitch on ch0 during WAIT_T2 (cycles 7..23).
        // lol sampled high at edges 16..18; last edge seen after 19,
        // CHECK after 20, WAIT_T2 21..37, NORMAL after 38, ready at 39.
        for (int ch = 0; ch < 2; ch++) begin
            s_on[ch] = -1; s_off[ch] = -1; r_on[ch] = -1; p_off[ch] = -1;
        end
        drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        for (int k = 0; k < 60; k++) begin
            step();
            for (int ch = 0; ch < 2; ch++) begin
                if (sq_if.rx_serdes_rst_ch_c[ch] && s_on[ch] < 0) s_on[ch] = cyc;
                if (!sq_if.rx_serdes_rst_ch_c[ch] && s_on[ch] >= 0 && s_off[ch] < 0) s_off[ch] = cyc;
                if (sq_if.rx_ready[ch] && r_on[ch] < 0) r_on[ch] = cyc;
                if (!sq_if.rx_pcs_rst_ch_c[ch] && p_off[ch] < 0) p_off[ch] = cyc;
            end
            if (cyc == 15) sq_if.rx_cdr_lol_ch_s = 2'b01;
            if (cyc == 18) sq_if.rx_cdr_lol_ch_s = 2'b00;
        end
        check("clean_serdes_on",    32'(s_on[1]),            32'd3);
        check("clean_serdes_len",   32'(s_off[1] - s_on[1]), 32'd4);
        check("clean_t2_window",    32'(r_on[1] - s_off[1]), 32'd18);
        check("clean_ready_cycle",  32'(r_on[1]),            32'd25);
        check("clean_pcs_fall",     32'(p_off[1]),           32'd25);
        check("glitch_serdes_on",   32'(s_on[0]),            32'd3);
        check("glitch_ready_cycle", 32'(r_on[0]),            32'd39);
        check("glitch_pcs_fall",    32'(p_off[0]),           32'd39);

        // Retry budget and FAULT latch on ch0
        drive(2'b01, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        run_until_fault(300, rises, found);
        check("retry_fault_seen",  32'(found), 32'd1);
        check("retry_attempts",    32'(rises), 32'd3);
        check("fault_pcs_held",    32'(sq_if.rx_pcs_rst_ch_c[0]),    32'd1);
        check("fault_serdes_low",  32'(sq_if.rx_serdes_rst_ch_c[0]), 32'd0);
        check("fault_ch1_ready",   32'(sq_if.rx_ready[1]),           32'd1);
        rises = 0;
        for (int k = 0; k < 30; k++) begin
            step();
            if (sq_if.rx_serdes_rst_ch_c[0]) rises++;
        end
        check("fault_latched",     32'(sq_if.rx_fault[0]), 32'd1);
        check("fault_no_attempts", 32'(rises),             32'd0);
        sq_if.fault_clr = 2'b10;
        step();
        sq_if.fault_clr = 2'b00;
        step();
        check("fclr_ch1_noeffect", 32'(sq_if.rx_ready[1]), 32'd1);
        check("fclr_ch1_fault0",   32'(sq_if.rx_fault[0]), 32'd1);
        sq_if.fault_clr = 2'b01;
        step();
        check("fclr_lag",          32'(sq_if.rx_fault[0]), 32'd1);
        sq_if.fault_clr = 2'b00;
        step();
        check("fclr_fault_low",    32'(sq_if.rx_fault[0]),           32'd0);
        check("fclr_serdes_pre",   32'(sq_if.rx_serdes_rst_ch_c[0]), 32'd0);
        step();
        check("fclr_restart",      32'(sq_if.rx_serdes_rst_ch_c[0]), 32'd1);

        // power_down clears the retry count: after it, three more attempts
        drive(2'b01, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        wait_rises(3, 200, found);
        check("pd_third_attempt", 32'(found), 32'd1);
        sq_if.power_down = 2'b01;
        repeat (3) step();
        check("pd_serdes_low", 32'(sq_if.rx_serdes_rst_ch_c[0]), 32'd0);
        sq_if.power_down = 2'b00;
        run_until_fault(300, rises, found);
        check("pd_fault_seen",    32'(found), 32'd1);
        check("pd_retry_cleared", 32'(rises), 32'd3);

        // PLL loss keeps the retry count: one more attempt faults
        drive(2'b01, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        wait_rises(3, 200, found);
        check("pll_third_attempt", 32'(found), 32'd1);
        sq_if.tx_pll_lol_qd_s = 1'b1;
        repeat (3) step();
        check("pll_serdes_low", 32'(sq_if.rx_serdes_rst_ch_c[0]), 32'd0);
        sq_if.tx_pll_lol_qd_s = 1'b0;
        run_until_fault(300, rises, found);
        check("pll_fault_seen",  32'(found), 32'd1);
        check("pll_retry_kept",  32'(rises), 32'd1);

        // PLL loss with both channels in NORMAL
        drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        repeat (30) step();
        check("pll_pre_ready", 32'(sq_if.rx_ready), 32'd3);
        sq_if.tx_pll_lol_qd_s = 1'b1;
        step();
        check("pll_lag1_ready", 32'(sq_if.rx_ready), 32'd3);
        step();
        check("pll_lag2_ready", 32'(sq_if.rx_ready),        32'd3);
        check("pll_lag2_pcs",   32'(sq_if.rx_pcs_rst_ch_c), 32'd0);
        step();
        check("pll_lost_ready", 32'(sq_if.rx_ready),        32'd0);
        check("pll_lost_pcs",   32'(sq_if.rx_pcs_rst_ch_c), 32'd3);
        sq_if.tx_pll_lol_qd_s = 1'b0;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (sq_if.rx_ready == 2'b11) begin
                found = 1;
                break;
            end
        end
        check("pll_relock", 32'(found), 32'd1);

        // power_down[1] lands during WAIT_T1: pulse cut to 2 cycles
        drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        step();
        step();
        sq_if.power_down = 2'b10;
        rises = 0;
        for (int k = 0; k < 50; k++) begin
            step();
            if (sq_if.rx_serdes_rst_ch_c[1]) rises++;
        end
        check("pd1_serdes_len", 32'(rises),                    32'd2);
        check("pd1_ready",      32'(sq_if.rx_ready),           32'd1);
        check("pd1_pcs",        32'(sq_if.rx_pcs_rst_ch_c),    32'd2);
        check("pd1_serdes",     32'(sq_if.rx_serdes_rst_ch_c), 32'd0);
        sq_if.power_down = 2'b00;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (sq_if.rx_ready[1]) begin
                found = 1;
                break;
            end
        end
        check("pd1_relock", 32'(found), 32'd1);

        // Mid-operation reset with ch0 in FAULT and ch1 in NORMAL
        drive(2'b01, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        run_until_fault(300, rises, found);
        check("mid_fault_seen", 32'(found), 32'd1);
        rst_n = 1'b0;
        step();
        check_reset_vals("mid_fault_rst");

        // Mid-operation reset during WAIT_T2, then a full clean relock
        drive(2'b00, 2'b00, 2'b00, 1'b0, 2'b00);
        do_reset();
        repeat (4) step();
        check("mid_t1_serdes", 32'(sq_if.rx_serdes_rst_ch_c), 32'd3);
        repeat (11) step();
        rst_n = 1'b0;
        step();
        check_reset_vals("mid_t2_rst");
        rst_n = 1'b1;
        cyc   = 0;
        found = 0;
        for (int k = 0; k < 60; k++) begin
            step();
            if (sq_if.rx_ready == 2'b11) begin
                found = cyc;
                break;
            end
        end
        check("mid_t2_relock_cycle", 32'(found), 32'd25);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
